// File: rtl/fifo_param.sv
// Synchronous FIFO with selectable registered or first-word-fall-through read,
// occupancy thresholds and sticky overflow/underflow error flags.
module fifo_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     enq,
   input  logic                     deq,
   input  logic                     flush,
   input  logic                     err_clr,
   output logic [WIDTH-1:0]         data_out,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          push, pop;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // flush suppresses both transfers and any error flag set that cycle
   assign push = enq && !full && !flush;
   assign pop  = deq && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      ovf_d = (ovf_q && !err_clr) || (enq && full && !flush);
      udf_d = (udf_q && !err_clr) || (deq && empty && !flush);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // gated so stale storage never shows while empty or in reset
         assign valid    = !empty;
         assign data_out = empty ? '0 : mem[rd_ptr_q];
      end else begin : g_reg
         logic [WIDTH-1:0] dout_q, dout_d;
         logic             valid_q, valid_d;

         always_comb begin
            dout_d  = dout_q;
            valid_d = pop;
            if (pop) dout_d = mem[rd_ptr_q];
         end

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               dout_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               dout_q  <= dout_d;
               valid_q <= valid_d;
            end
         end

         assign data_out = dout_q;
         assign valid    = valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: registered and FWFT instances driven in lockstep,
// checked against a queue-based reference model.
module tb_fifo_param;

   localparam int D = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enq, deq, flush, err_clr;
   logic [31:0] data_in;

   logic [31:0] dout0, dout1;
   logic        val0, full0, empty0, af0, ae0, ovf0, udf0;
   logic        val1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [4:0]  cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] q[$];
   logic [31:0] m_dout;
   logic        m_val, m_ovf, m_udf;

   always #5 clk = ~clk;

   fifo_param #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut (
      .clk(clk), .rstn(rstn), .data_in(data_in), .enq(enq), .deq(deq),
      .flush(flush), .err_clr(err_clr), .data_out(dout0), .valid(val0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .count(cnt0), .overflow(ovf0), .underflow(udf0)
   );

   fifo_param #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_dut_f (
      .clk(clk), .rstn(rstn), .data_in(data_in), .enq(enq), .deq(deq),
      .flush(flush), .err_clr(err_clr), .data_out(dout1), .valid(val1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .count(cnt1), .overflow(ovf1), .underflow(udf1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_val  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   // rules applied to the state seen before the edge
   task automatic model_edge(input logic e, input logic d, input logic f,
                             input logic c, input logic [31:0] din);
      int  n = q.size();
      bit  is_full = (n == D);
      bit  is_empty = (n == 0);
      bit  do_push = e && !is_full && !f;
      bit  do_pop  = d && !is_empty && !f;
      m_ovf = (m_ovf && !c) || (e && is_full && !f);
      m_udf = (m_udf && !c) || (d && is_empty && !f);
      m_val = do_pop;
      if (f) q.delete();
      else begin
         if (do_pop) m_dout = q.pop_front();
         if (do_push) q.push_back(din);
      end
   endtask

   task automatic check_all();
      int n = q.size();
      chk("count0", 32'(cnt0), n);
      chk("full0", 32'(full0), 32'(n == D));
      chk("empty0", 32'(empty0), 32'(n == 0));
      chk("afull0", 32'(af0), 32'(n >= 14));
      chk("aempty0", 32'(ae0), 32'(n <= 2));
      chk("ovf0", 32'(ovf0), 32'(m_ovf));
      chk("udf0", 32'(udf0), 32'(m_udf));
      chk("valid0", 32'(val0), 32'(m_val));
      chk("dout0", dout0, m_dout);
      chk("count1", 32'(cnt1), n);
      chk("full1", 32'(full1), 32'(n == D));
      chk("afull1", 32'(af1), 32'(n >= 14));
      chk("aempty1", 32'(ae1), 32'(n <= 2));
      chk("ovf1", 32'(ovf1), 32'(m_ovf));
      chk("udf1", 32'(udf1), 32'(m_udf));
      chk("valid1", 32'(val1), 32'(n != 0));
      if (n != 0) chk("dout1", dout1, q[0]);
   endtask

   task automatic chk_reset();
      chk("rst_count0", 32'(cnt0), 0);
      chk("rst_dout0", dout0, 0);
      chk("rst_valid0", 32'(val0), 0);
      chk("rst_empty0", 32'(empty0), 1);
      chk("rst_aempty0", 32'(ae0), 1);
      chk("rst_full0", 32'(full0), 0);
      chk("rst_afull0", 32'(af0), 0);
      chk("rst_ovf0", 32'(ovf0), 0);
      chk("rst_udf0", 32'(udf0), 0);
      chk("rst_count1", 32'(cnt1), 0);
      chk("rst_dout1", dout1, 0);
      chk("rst_valid1", 32'(val1), 0);
      chk("rst_empty1", 32'(empty1), 1);
      chk("rst_ovf1", 32'(ovf1), 0);
      chk("rst_udf1", 32'(udf1), 0);
   endtask

   task automatic step(input logic e, input logic d, input logic f,
                       input logic c, input logic [31:0] din);
      enq = e; deq = d; flush = f; err_clr = c; data_in = din;
      @(posedge clk);
      model_edge(e, d, f, c, din);
      @(negedge clk);
      check_all();
   endtask

   task automatic push(input logic [31:0] din);
      step(1'b1, 1'b0, 1'b0, 1'b0, din);
   endtask

   task automatic pop();
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic clr();
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   initial begin
      rstn = 1'b0; enq = 0; deq = 0; flush = 0; err_clr = 0; data_in = '0;
      model_reset();
      #1 chk_reset();
      @(negedge clk); @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_all();

      // fill past full, then drain past empty
      for (int i = 0; i < 17; i++) push(32'(i));
      chk("fill_ovf", 32'(ovf0), 1);
      for (int i = 0; i < 17; i++) pop();
      chk("drain_udf", 32'(udf0), 1);
      clr();

      // simultaneous push+pop at mid, full and empty
      for (int i = 0; i < 5; i++) push(32'h50 + 32'(i));
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h55);
      chk("sim5_count", 32'(cnt0), 5);
      while (q.size() < D) push($urandom);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD);
      chk("sim16_count", 32'(cnt0), 15);
      while (q.size() > 0) pop();
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'hBEEF);
      chk("sim0_count", 32'(cnt0), 1);
      pop();
      clr();

      // interleaved traffic to wrap both pointers
      for (int i = 0; i < 40; i++) begin
         push(32'h100 + 32'(i));
         pop();
      end

      // flush at count 9 with enq asserted and overflow pending
      while (q.size() < D) push($urandom);
      push(32'h77);
      for (int i = 0; i < 7; i++) pop();
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'hF1F1F1F1);
      chk("flush_empty", 32'(empty0), 1);
      chk("flush_ovf", 32'(ovf0), 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      clr();

      // FWFT visibility, then asynchronous reset mid-cycle
      push(32'hA5A5A5A5);
      chk("fwft_dout", dout1, 32'hA5A5A5A5);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("fwft_hold", 32'(val1), 1);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1 chk_reset();
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_all();

      // randomized traffic with shifting bias to hit both ends
      for (int blk = 0; blk < 20; blk++) begin
         int bias = $urandom_range(10, 90);
         for (int i = 0; i < 80; i++) begin
            logic e = ($urandom_range(99) < bias);
            logic d = ($urandom_range(99) >= bias);
            logic f = ($urandom_range(63) == 0);
            logic c = ($urandom_range(31) == 0);
            if ($urandom_range(3) == 0) begin
               e = $urandom_range(1);
               d = $urandom_range(1);
            end
            step(e, d, f, c, $urandom);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
